// File: rtl/memory_controller.sv
// Single-port RAM sequencer: latches one CPU request, range-checks it, and runs the
// matching write or read/capture sequence against a synchronous RAM before a one-cycle ack.
module memory_controller #(
   parameter int ADDR_BITS  = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  req,
   input  logic                  we,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ack,
   output logic                  err,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_BITS-1:0]  ram_addr,
   output logic [DATA_WIDTH-1:0] ram_d,
   output logic                  ram_read,
   output logic                  ram_write,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      ACK     = 3'd4
   } state_t;

   state_t                state, state_next;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  err_q;
   logic                  out_of_range;

   // Any set bit above the RAM word range rejects the request.
   assign out_of_range = (addr[31:ADDR_BITS] != '0);

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata   <= '0;
      end else begin
         if (state == IDLE && req) begin
            addr_q  <= addr[ADDR_BITS-1:0];
            wdata_q <= wdata;
            we_q    <= we;
            err_q   <= out_of_range;
         end
         if (state == CAPTURE) begin
            rdata <= ram_q;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (out_of_range) state_next = ACK;
               else if (we)      state_next = WRITE;
               else              state_next = READ;
            end
         end
         WRITE:   state_next = ACK;
         READ:    state_next = CAPTURE;
         CAPTURE: state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // RAM strobes come from state; the latched direction only guards against a corrupt state.
   assign ram_write = (state == WRITE) && we_q;
   assign ram_read  = (state == READ) && !we_q;
   assign ram_addr  = addr_q;
   assign ram_d     = wdata_q;
   assign ack       = (state == ACK);
   assign err       = (state == ACK) && err_q;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_memory_controller.sv
// Directed and randomized bench for memory_controller: a synchronous RAM model plus a
// transaction-level reference (memory image, expected latency/err/rdata per request).
module tb_memory_controller;
  localparam int AB = 9;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          clear, req, we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata, rdata, ram_d, ram_q;
  logic [AB-1:0] ram_addr;
  logic          ack, err, busy, ram_read, ram_write;
  logic [2:0]    dbg_state;

  logic [DW-1:0] ram     [512];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] ref_rdata;
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  memory_controller #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clock(clock), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .busy(busy), .rdata(rdata), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_read(ram_read), .ram_write(ram_write), .ram_q(ram_q),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;

  // synchronous RAM: write on the strobe edge, read data valid one edge after ram_read
  always @(posedge clock) begin
    if (ram_write) ram[ram_addr] <= ram_d;
    if (ram_read)  ram_q <= ram[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ram_read"}, ram_read, 0);
    check({tag, "_ram_write"}, ram_write, 0);
  endtask

  // driver + scoreboard for one isolated transaction
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [DW-1:0] t_wdata);
    bit in_range;
    int exp_lat, lat, n_wr, n_rd;
    logic [DW-1:0] exp_rd;
    in_range = (t_addr[31:9] == 23'd0);
    exp_lat  = !in_range ? 1 : (t_we ? 2 : 3);
    lat = 0; n_wr = 0; n_rd = 0;
    if (in_range && t_we)  ref_mem[t_addr[8:0]] = t_wdata;
    if (in_range && !t_we) ref_rdata = ref_mem[t_addr[8:0]];
    exp_q.push_back(ref_rdata);

    @(negedge clock);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check("busy_during_txn", busy, 1);
      check("err_only_on_reject_ack", err, ack && !in_range);
      check("no_dual_strobe", ram_read && ram_write, 0);
      if (ram_write) begin
        n_wr++;
        check("ram_addr_wr", ram_addr, t_addr[8:0]);
        check("ram_d_wr", ram_d, t_wdata);
      end
      if (ram_read) begin
        n_rd++;
        check("ram_addr_rd", ram_addr, t_addr[8:0]);
      end
      if (ack) begin
        lat = k;
        break;
      end
      // requester drops req and scribbles on the bus while busy
      req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    end
    req = 1'b0;
    check("ack_latency", lat, exp_lat);
    check("write_strobes", n_wr, (in_range && t_we) ? 1 : 0);
    check("read_strobes", n_rd, (in_range && !t_we) ? 1 : 0);
    exp_rd = exp_q.pop_front();
    check("rdata_at_ack", rdata, exp_rd);
    @(negedge clock);
    check_idle_outputs("post_ack");
    if (in_range) check("ram_contents", ram[t_addr[8:0]], ref_mem[t_addr[8:0]]);
  endtask

  initial begin
    logic [DW-1:0] w0, w1, old_word;
    int n_ack, first_k, second_k;

    foreach (ram[i]) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram_q = '0; ref_rdata = '0;
    clear = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1;
    check_idle_outputs("in_reset");
    check("reset_rdata", rdata, 0);
    check("reset_ram_addr", ram_addr, 0);
    check("reset_ram_d", ram_d, 0);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check_idle_outputs("after_reset");

    // basic write/read, reject, range boundary
    run_txn(1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_0005, $urandom);
    check("read_back_deadbeef", rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_0200, $urandom);
    check("reject_keeps_rdata", rdata, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0000_0200, 32'h1234_5678);
    run_txn(1'b1, 32'h8000_0005, 32'h1234_5678);
    run_txn(1'b0, 32'h0000_0005, 32'h0);

    // back-to-back reads with req held high
    w1 = $urandom; w0 = $urandom;
    run_txn(1'b1, 32'h0000_01FF, w1);
    run_txn(1'b1, 32'h0000_0000, w0);
    exp_q.push_back(w1);
    exp_q.push_back(w0);
    n_ack = 0; first_k = 0; second_k = 0;
    @(negedge clock);
    req = 1'b1; we = 1'b0; addr = 32'h0000_01FF;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      check("b2b_no_err", err, 0);
      if (ack) begin
        n_ack++;
        check("b2b_rdata", rdata, exp_q.pop_front());
        if (n_ack == 1) first_k = k;
        else second_k = k;
      end
      if (n_ack >= 2) begin
        req = 1'b0;
        break;
      end
      if (n_ack == 1 && (k == first_k || k == first_k + 1)) addr = 32'h0;
      else addr = $urandom;
      we = 1'($urandom);
      if (n_ack == 0 || k > first_k + 1) we = 1'($urandom);
      else we = 1'b0;
    end
    req = 1'b0;
    check("b2b_ack_count", n_ack, 2);
    check("b2b_first_latency", first_k, 3);
    check("b2b_ack_spacing", second_k - first_k, 4);
    ref_rdata = w0;
    @(negedge clock);
    check_idle_outputs("b2b_done");

    // clear in the middle of a write
    old_word = ref_mem[9'h0AB];
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 32'h0000_00AB; wdata = ~old_word;
    @(negedge clock);
    req = 1'b0;
    check("abort_write_strobe_before", ram_write, 1);
    #2 clear = 1'b1;
    #1;
    check("abort_ram_write_dropped", ram_write, 0);
    check("abort_busy_dropped", busy, 0);
    check("abort_rdata_cleared", rdata, 0);
    ref_rdata = '0;
    @(negedge clock);
    clear = 1'b0;
    n_ack = 0;
    repeat (4) begin
      @(negedge clock);
      if (ack) n_ack++;
    end
    check("abort_no_ack", n_ack, 0);
    check("abort_word_unchanged", ram[9'h0AB], old_word);
    run_txn(1'b1, 32'h0000_00AB, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h0000_00AB, 32'h0);

    // randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 511));
      else if (sel == 6) a = 32'h0000_01FF;
      else if (sel == 7) a = 32'h0000_0200;
      else               a = {23'($urandom_range(1, 32'h7F_FFFF)), 9'($urandom_range(0, 511))};
      run_txn(1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
